hds_rd_resp_tagger: RTL and testbench

Per-segment tag tracker directly upstream of the header/data-split shim on the DMA RAM read path. Observes segmented read commands as they are accepted by the RAM. Records whether each beat belongs to the packet header region in an in-order tag FIFO per segment. Presents the matching `hdr`/`sop` tag alongside each read response, so the split stage knows exactly which response beats to cut.

---
 rtl/hds_rd_resp_tagger.sv | 118 +++++++++++
 tb/tb_hds_rd_resp_tagger.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hds_rd_resp_tagger.sv
// hds_rd_resp_tagger: per-segment in-order {sop,hdr} tag FIFOs that shadow DMA RAM read commands.
// Sticky tag_err detection is built only when HDS_RESP_TAG_ERR_EN is defined.
module hds_rd_resp_tagger #(
    parameter int RAM_SEG_COUNT      = 2,
    parameter int RAM_SEG_DATA_WIDTH = 256,
    parameter int TAG_FIFO_AW        = 3,
    parameter int BEAT_CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pkt_start,
    input  logic [7:0]               pkt_hdr_beats,
    input  logic [RAM_SEG_COUNT-1:0] cmd_valid_in,
    input  logic [RAM_SEG_COUNT-1:0] cmd_ready_in,
    output logic [RAM_SEG_COUNT-1:0] cmd_valid_out,
    output logic [RAM_SEG_COUNT-1:0] cmd_ready_out,
    input  logic [RAM_SEG_COUNT-1:0] resp_valid,
    input  logic [RAM_SEG_COUNT-1:0] resp_ready,
    output logic [RAM_SEG_COUNT-1:0] resp_hdr,
    output logic [RAM_SEG_COUNT-1:0] resp_sop,
    output logic [1:0]               tag_err
);
    localparam int DEPTH = 1 << TAG_FIFO_AW;
    localparam int CNT_W = $clog2(RAM_SEG_COUNT + 1);
    localparam logic [TAG_FIFO_AW:0] PTR_ONE = (TAG_FIFO_AW + 1)'(1);
    // A segment with no data path never accepts commands.
    localparam logic SEG_EN = (RAM_SEG_DATA_WIDTH > 0);

    logic [TAG_FIFO_AW:0]      wr_ptr   [RAM_SEG_COUNT];
    logic [TAG_FIFO_AW:0]      rd_ptr   [RAM_SEG_COUNT];
    logic [1:0]                mem      [RAM_SEG_COUNT][DEPTH];
    logic [1:0]                push_tag [RAM_SEG_COUNT];
    logic [BEAT_CNT_WIDTH-1:0] push_idx [RAM_SEG_COUNT];
    logic [RAM_SEG_COUNT-1:0]  full, empty, push, pop;
    logic [BEAT_CNT_WIDTH-1:0] beat_idx, idx_base, idx_next;
    logic [7:0]                hdr_beats_q, hdr_lim;

    function automatic logic [BEAT_CNT_WIDTH-1:0] sat_add(
        input logic [BEAT_CNT_WIDTH-1:0] a,
        input logic [CNT_W-1:0]          b
    );
        logic [BEAT_CNT_WIDTH:0] sum;
        sum = {1'b0, a} + {{(BEAT_CNT_WIDTH + 1 - CNT_W){1'b0}}, b};
        return sum[BEAT_CNT_WIDTH] ? '1 : sum[BEAT_CNT_WIDTH-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < RAM_SEG_COUNT; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][TAG_FIFO_AW] != rd_ptr[i][TAG_FIFO_AW]) &&
                       (wr_ptr[i][TAG_FIFO_AW-1:0] == rd_ptr[i][TAG_FIFO_AW-1:0]);
            cmd_valid_out[i] = cmd_valid_in[i] & ~full[i] & SEG_EN;
            cmd_ready_out[i] = cmd_ready_in[i] & ~full[i] & SEG_EN;
            push[i] = cmd_valid_in[i] & cmd_ready_in[i] & ~full[i] & SEG_EN;
            pop[i]  = resp_valid[i] & resp_ready[i] & ~empty[i];
            resp_hdr[i] = ~empty[i] & mem[i][rd_ptr[i][TAG_FIFO_AW-1:0]][0];
            resp_sop[i] = ~empty[i] & mem[i][rd_ptr[i][TAG_FIFO_AW-1:0]][1];
        end
    end

    // Commands accepted together take consecutive beat indices, lowest segment first.
    always_comb begin
        logic [CNT_W-1:0] ofs;
        ofs      = '0;
        idx_base = pkt_start ? '0 : beat_idx;
        hdr_lim  = pkt_start ? pkt_hdr_beats : hdr_beats_q;
        for (int i = 0; i < RAM_SEG_COUNT; i++) begin
            push_idx[i] = sat_add(idx_base, ofs);
            push_tag[i] = {push_idx[i] == '0,
                           push_idx[i] < {{(BEAT_CNT_WIDTH - 8){1'b0}}, hdr_lim}};
            ofs = ofs + CNT_W'(push[i]);
        end
        idx_next = sat_add(idx_base, ofs);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAM_SEG_COUNT; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            beat_idx    <= '0;
            hdr_beats_q <= '0;
        end else begin
            for (int i = 0; i < RAM_SEG_COUNT; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
            end
            if (pkt_start) hdr_beats_q <= pkt_hdr_beats;
            beat_idx <= idx_next;
        end
    end

    // Tag storage has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RAM_SEG_COUNT; i++) begin
            if (push[i]) mem[i][wr_ptr[i][TAG_FIFO_AW-1:0]] <= push_tag[i];
        end
    end

`ifdef HDS_RESP_TAG_ERR_EN
    logic [1:0] err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            if (|(resp_valid & resp_ready & empty)) err_q[0] <= 1'b1;
            if (pkt_start && !(&empty))             err_q[1] <= 1'b1;
        end
    end

    assign tag_err = err_q;
`else
    assign tag_err = 2'b00;
`endif

endmodule

// File: tb/tb_hds_rd_resp_tagger.sv
// Self-checking bench for hds_rd_resp_tagger: directed steps then random traffic against a queue model.
module tb_hds_rd_resp_tagger;
    localparam int DEPTH   = 8;
    localparam int IDX_MAX = 65535;

    logic       clk = 1'b0;
    logic       rst, pkt_start;
    logic [7:0] pkt_hdr_beats;
    logic [1:0] cmd_valid_in, cmd_ready_in, cmd_valid_out, cmd_ready_out;
    logic [1:0] resp_valid, resp_ready, resp_hdr, resp_sop, tag_err;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    logic [1:0] q0[$];
    logic [1:0] q1[$];
    int         m_idx = 0;
    int         m_hb  = 0;
    logic [1:0] m_err = 2'b00;

    always #5 clk = ~clk;

    hds_rd_resp_tagger dut (
        .clk(clk), .rst(rst), .pkt_start(pkt_start), .pkt_hdr_beats(pkt_hdr_beats),
        .cmd_valid_in(cmd_valid_in), .cmd_ready_in(cmd_ready_in),
        .cmd_valid_out(cmd_valid_out), .cmd_ready_out(cmd_ready_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_hdr(resp_hdr), .resp_sop(resp_sop), .tag_err(tag_err)
    );

    function automatic int qsize(input int s);
        return (s == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [1:0] qhead(input int s);
        return (s == 0) ? q0[0] : q1[0];
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Check the current cycle against the model, advance the model, then cross the clock edge.
    task automatic step();
        logic [1:0] e_cvo, e_cro, e_hdr, e_sop, pushm, popm, h, e_err;
        logic       under, busy;
        #1;
        under = 1'b0;
        busy  = 1'b0;
        for (int s = 0; s < 2; s++) begin
            h = (qsize(s) == 0) ? 2'b00 : qhead(s);
            e_cvo[s] = cmd_valid_in[s] && (qsize(s) != DEPTH);
            e_cro[s] = cmd_ready_in[s] && (qsize(s) != DEPTH);
            e_sop[s] = h[1];
            e_hdr[s] = h[0];
            pushm[s] = cmd_valid_in[s] && cmd_ready_in[s] && (qsize(s) != DEPTH);
            popm[s]  = resp_valid[s] && resp_ready[s] && (qsize(s) != 0);
            if (resp_valid[s] && resp_ready[s] && qsize(s) == 0) under = 1'b1;
            if (qsize(s) != 0) busy = 1'b1;
        end
`ifdef HDS_RESP_TAG_ERR_EN
        e_err = m_err;
`else
        e_err = 2'b00;
`endif
        chk("cmd_valid_out", cmd_valid_out, e_cvo);
        chk("cmd_ready_out", cmd_ready_out, e_cro);
        chk("resp_sop", resp_sop, e_sop);
        chk("resp_hdr", resp_hdr, e_hdr);
        chk("tag_err", tag_err, e_err);

        if (rst) begin
            q0.delete();
            q1.delete();
            m_idx = 0;
            m_hb  = 0;
            m_err = 2'b00;
        end else begin
            if (under) m_err[0] = 1'b1;
            if (pkt_start && busy) m_err[1] = 1'b1;
            if (popm[0]) void'(q0.pop_front());
            if (popm[1]) void'(q1.pop_front());
            if (pkt_start) begin
                m_idx = 0;
                m_hb  = int'(pkt_hdr_beats);
            end
            for (int s = 0; s < 2; s++) begin
                if (pushm[s]) begin
                    h = {m_idx == 0, m_idx < m_hb};
                    if (s == 0) q0.push_back(h);
                    else        q1.push_back(h);
                    if (m_idx < IDX_MAX) m_idx++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic ps, input logic [7:0] hb,
                         input logic [1:0] cv, input logic [1:0] cr,
                         input logic [1:0] rv, input logic [1:0] rr);
        rst           = r;
        pkt_start     = ps;
        pkt_hdr_beats = hb;
        cmd_valid_in  = cv;
        cmd_ready_in  = cr;
        resp_valid    = rv;
        resp_ready    = rr;
        step();
    endtask

    initial begin
        rst = 1'b1; pkt_start = 1'b0; pkt_hdr_beats = '0;
        cmd_valid_in = '0; cmd_ready_in = '0; resp_valid = '0; resp_ready = '0;
        @(posedge clk);
        #1;
        drive(1, 0, 0, 2'b00, 2'b11, 2'b00, 2'b00);
        drive(1, 0, 0, 2'b00, 2'b11, 2'b00, 2'b00);
        drive(0, 0, 0, 2'b00, 2'b11, 2'b00, 2'b00);

        // Header of 2 beats, 4 commands on segment 0, then 4 responses.
        drive(0, 1, 2, 2'b00, 2'b11, 2'b00, 2'b00);
        repeat (4) drive(0, 0, 0, 2'b01, 2'b11, 2'b00, 2'b00);
        repeat (4) drive(0, 0, 0, 2'b00, 2'b11, 2'b01, 2'b01);

        // Both segments accept in the same cycle with a 1-beat header.
        drive(0, 1, 1, 2'b00, 2'b11, 2'b00, 2'b00);
        drive(0, 0, 0, 2'b11, 2'b11, 2'b00, 2'b00);
        drive(0, 0, 0, 2'b00, 2'b11, 2'b11, 2'b11);

        // Fill segment 0, pop while full with a competing push, then drain.
        drive(0, 1, 4, 2'b00, 2'b11, 2'b00, 2'b00);
        repeat (8) drive(0, 0, 0, 2'b01, 2'b11, 2'b00, 2'b00);
        drive(0, 0, 0, 2'b01, 2'b11, 2'b00, 2'b00);
        drive(0, 0, 0, 2'b01, 2'b11, 2'b01, 2'b01);
        drive(0, 0, 0, 2'b01, 2'b11, 2'b00, 2'b00);
        repeat (9) drive(0, 0, 0, 2'b00, 2'b11, 2'b01, 2'b01);

        // pkt_start together with an accepted command, header length 3 -> 0.
        drive(0, 1, 3, 2'b00, 2'b11, 2'b00, 2'b00);
        drive(0, 1, 0, 2'b01, 2'b11, 2'b00, 2'b00);
        drive(0, 0, 0, 2'b00, 2'b11, 2'b01, 2'b01);

        // Response against an empty FIFO, then idle to observe stickiness.
        drive(0, 0, 0, 2'b00, 2'b11, 2'b10, 2'b10);
        repeat (2) drive(0, 0, 0, 2'b00, 2'b11, 2'b00, 2'b00);

        // Reset with 3 tags queued, then one in-flight response.
        drive(0, 1, 2, 2'b01, 2'b11, 2'b00, 2'b00);
        repeat (2) drive(0, 0, 0, 2'b01, 2'b11, 2'b00, 2'b00);
        drive(1, 0, 0, 2'b00, 2'b11, 2'b00, 2'b00);
        drive(0, 0, 0, 2'b00, 2'b11, 2'b01, 2'b01);
        repeat (2) drive(0, 0, 0, 2'b00, 2'b11, 2'b00, 2'b00);

        // pkt_start while tags are still queued.
        drive(0, 1, 1, 2'b01, 2'b11, 2'b00, 2'b00);
        drive(0, 1, 1, 2'b00, 2'b11, 2'b00, 2'b00);
        drive(0, 0, 0, 2'b00, 2'b11, 2'b01, 2'b01);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            drive(($urandom % 97) == 0, ($urandom % 12) == 0, 8'($urandom % 6),
                  2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
